// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs for RS and LSB, drained round-robin onto a
// registered common data bus that writes back to the ROB and wakes waiting entries.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_WIDTH = 1
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 clear,
    input  logic                 rsValid,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsValue,
    output logic                 rsFull,
    input  logic                 lsbValid,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbValue,
    output logic                 lsbFull,
    output logic                 cdbValid,
    output logic [ROB_WIDTH-1:0] cdbRobIndex,
    output logic [31:0]          cdbValue
);

    localparam int unsigned DEPTH = 2 ** FIFO_WIDTH;

    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    logic [ROB_WIDTH-1:0]  rsMemIdx_q  [DEPTH];
    logic [31:0]           rsMemVal_q  [DEPTH];
    logic [ROB_WIDTH-1:0]  lsbMemIdx_q [DEPTH];
    logic [31:0]           lsbMemVal_q [DEPTH];

    logic [FIFO_WIDTH-1:0] rsHead_q, rsHead_d, rsTail_q, rsTail_d;
    logic [FIFO_WIDTH-1:0] lsbHead_q, lsbHead_d, lsbTail_q, lsbTail_d;
    logic [FIFO_WIDTH:0]   rsCount_q, rsCount_d, lsbCount_q, lsbCount_d;
    src_e                  lastGrant_q, lastGrant_d;
    logic                  cdbValid_q, cdbValid_d;
    logic [ROB_WIDTH-1:0]  cdbRobIndex_q, cdbRobIndex_d;
    logic [31:0]           cdbValue_q, cdbValue_d;

    logic advance;
    logic rsPush, lsbPush, rsPop, lsbPop;
    logic rsNonEmpty, lsbNonEmpty;

    // Full flags look only at the registered count; a same-cycle pop never frees a slot.
    assign rsFull  = (rsCount_q  == (FIFO_WIDTH+1)'(DEPTH));
    assign lsbFull = (lsbCount_q == (FIFO_WIDTH+1)'(DEPTH));

    assign advance     = readyIn & ~clear;
    assign rsNonEmpty  = (rsCount_q  != '0);
    assign lsbNonEmpty = (lsbCount_q != '0);
    assign rsPush      = advance & rsValid  & ~rsFull;
    assign lsbPush     = advance & lsbValid & ~lsbFull;
    assign rsPop       = advance & rsNonEmpty  & (~lsbNonEmpty | (lastGrant_q == SRC_LSB));
    assign lsbPop      = advance & lsbNonEmpty & (~rsNonEmpty  | (lastGrant_q == SRC_RS));

    always_comb begin
        rsHead_d      = rsHead_q;
        rsTail_d      = rsTail_q;
        rsCount_d     = rsCount_q;
        lsbHead_d     = lsbHead_q;
        lsbTail_d     = lsbTail_q;
        lsbCount_d    = lsbCount_q;
        lastGrant_d   = lastGrant_q;
        cdbValid_d    = cdbValid_q;
        cdbRobIndex_d = cdbRobIndex_q;
        cdbValue_d    = cdbValue_q;

        if (clear) begin
            rsHead_d    = '0;
            rsTail_d    = '0;
            rsCount_d   = '0;
            lsbHead_d   = '0;
            lsbTail_d   = '0;
            lsbCount_d  = '0;
            lastGrant_d = SRC_LSB;
            cdbValid_d  = 1'b0;
        end else if (readyIn) begin
            if (rsPush)  rsTail_d  = rsTail_q + 1'b1;
            if (lsbPush) lsbTail_d = lsbTail_q + 1'b1;
            if (rsPop)   rsHead_d  = rsHead_q + 1'b1;
            if (lsbPop)  lsbHead_d = lsbHead_q + 1'b1;

            case ({rsPush, rsPop})
                2'b10:   rsCount_d = rsCount_q + 1'b1;
                2'b01:   rsCount_d = rsCount_q - 1'b1;
                default: rsCount_d = rsCount_q;
            endcase
            case ({lsbPush, lsbPop})
                2'b10:   lsbCount_d = lsbCount_q + 1'b1;
                2'b01:   lsbCount_d = lsbCount_q - 1'b1;
                default: lsbCount_d = lsbCount_q;
            endcase

            cdbValid_d = rsPop | lsbPop;
            if (rsPop) begin
                lastGrant_d   = SRC_RS;
                cdbRobIndex_d = rsMemIdx_q[rsHead_q];
                cdbValue_d    = rsMemVal_q[rsHead_q];
            end else if (lsbPop) begin
                lastGrant_d   = SRC_LSB;
                cdbRobIndex_d = lsbMemIdx_q[lsbHead_q];
                cdbValue_d    = lsbMemVal_q[lsbHead_q];
            end
        end
    end

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            rsHead_q      <= '0;
            rsTail_q      <= '0;
            rsCount_q     <= '0;
            lsbHead_q     <= '0;
            lsbTail_q     <= '0;
            lsbCount_q    <= '0;
            lastGrant_q   <= SRC_LSB;
            cdbValid_q    <= 1'b0;
            cdbRobIndex_q <= '0;
            cdbValue_q    <= '0;
        end else begin
            rsHead_q      <= rsHead_d;
            rsTail_q      <= rsTail_d;
            rsCount_q     <= rsCount_d;
            lsbHead_q     <= lsbHead_d;
            lsbTail_q     <= lsbTail_d;
            lsbCount_q    <= lsbCount_d;
            lastGrant_q   <= lastGrant_d;
            cdbValid_q    <= cdbValid_d;
            cdbRobIndex_q <= cdbRobIndex_d;
            cdbValue_q    <= cdbValue_d;
        end
    end

    // Payload storage needs no reset; the counts alone decide what is valid.
    always_ff @(posedge clockIn) begin
        if (rsPush) begin
            rsMemIdx_q[rsTail_q] <= rsRobIndex;
            rsMemVal_q[rsTail_q] <= rsValue;
        end
        if (lsbPush) begin
            lsbMemIdx_q[lsbTail_q] <= lsbRobIndex;
            lsbMemVal_q[lsbTail_q] <= lsbValue;
        end
    end

    assign cdbValid    = cdbValid_q;
    assign cdbRobIndex = cdbRobIndex_q;
    assign cdbValue    = cdbValue_q;

endmodule
